// File: rtl/cntr8_pkg.sv
// ---------------------------------------------------------------------------
// cntr8_pkg
// Shared definitions for the up/down counter receive-side decoder.
//   - DEFAULT_WIDTH : default observed counter width
//   - ST_*          : 3-bit decoded state codes presented on the state output
//   - step_t        : classification of one sample against the previous one
// ---------------------------------------------------------------------------
package cntr8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Decoded state codes; 3'b110 / 3'b111 are unused.
  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_SYNC = 3'b001;
  localparam logic [2:0] ST_INC  = 3'b010;
  localparam logic [2:0] ST_DEC  = 3'b011;
  localparam logic [2:0] ST_HOLD = 3'b100;
  localparam logic [2:0] ST_ERR  = 3'b101;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_SAME = 2'd2,
    STEP_JUMP = 2'd3
  } step_t;

endpackage

// File: rtl/cntr8_step_cmp.sv
// ---------------------------------------------------------------------------
// cntr8_step_cmp
// Combinational classifier: compares the new sample against the previous one
// modulo 2^WIDTH.
// Ports:
//   prev      in  WIDTH  previously accepted sample
//   cur       in  WIDTH  new sample
//   step      out step_t UP / DOWN / SAME / JUMP
//   wrap_cand out 1      step is a legal +1 or -1 that crosses the modular boundary
// ---------------------------------------------------------------------------
module cntr8_step_cmp
  import cntr8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output step_t            step,
  output logic             wrap_cand
);

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;

  // Sized intermediates keep the +/-1 comparisons modulo 2^WIDTH.
  assign prev_inc = prev + 1'b1;
  assign prev_dec = prev - 1'b1;

  always_comb begin
    step = STEP_JUMP;
    if (cur == prev) begin
      step = STEP_SAME;
    end else if (cur == prev_inc) begin
      step = STEP_UP;
    end else if (cur == prev_dec) begin
      step = STEP_DOWN;
    end
  end

  // An up step from all-ones necessarily lands on zero (and vice versa).
  assign wrap_cand = ((step == STEP_UP)   && (prev == '1)) ||
                     ((step == STEP_DOWN) && (prev == '0));

endmodule

// File: rtl/cntr8_decoder.sv
// ---------------------------------------------------------------------------
// cntr8_decoder
// Receive-side monitor for an up/down counter output bus. Each accepted
// sample is classified against the previous one; the counter's operating
// mode is recovered as a 3-bit code, modular wrap is flagged, and illegal
// jumps are counted in a saturating error counter.
//
// Build option: define CNTR8_DECODER_AUTO_RESYNC_EN to let the decoder leave
// ERR on the next accepted sample (relock via SYNC, err_cnt retained).
// Without it ERR is sticky until clr or reset_n.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   clr      in   1      synchronous clear (priority over d_valid)
//   d_valid  in   1      d_in carries a new sample
//   d_in     in   WIDTH  observed counter value
//   state    out  3      decoded state code (registered)
//   d_out    out  WIDTH  last accepted sample (registered)
//   wrap     out  1      one-cycle pulse on modular wrap (registered)
//   err_cnt  out  ERR_W  saturating count of illegal steps
// ---------------------------------------------------------------------------
module cntr8_decoder
  import cntr8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_in,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] d_out,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  logic [2:0]       state_reg, state_next;
  logic [WIDTH-1:0] dout_reg,  dout_next;
  logic             wrap_reg,  wrap_next;
  logic [ERR_W-1:0] err_reg,   err_next;

  step_t step;
  logic  wrap_cand;

  cntr8_step_cmp #(
    .WIDTH (WIDTH)
  ) u_step_cmp (
    .prev      (dout_reg),
    .cur       (d_in),
    .step      (step),
    .wrap_cand (wrap_cand)
  );

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    wrap_next  = 1'b0;
    err_next   = err_reg;

    if (clr) begin
      state_next = ST_IDLE;
      dout_next  = '0;
      err_next   = '0;
    end else if (d_valid) begin
      dout_next = d_in;
      case (state_reg)
        ST_IDLE: state_next = ST_SYNC;
        ST_SYNC, ST_INC, ST_DEC, ST_HOLD: begin
          wrap_next = wrap_cand;
          case (step)
            STEP_UP:   state_next = ST_INC;
            STEP_DOWN: state_next = ST_DEC;
            STEP_SAME: state_next = ST_HOLD;
            default: begin
              // Before a direction is known a jump just re-seeds the
              // reference; once locked it is a protocol error.
              if (state_reg != ST_SYNC) begin
                state_next = ST_ERR;
                if (err_reg != '1) begin
                  err_next = err_reg + 1'b1;
                end
              end
            end
          endcase
        end
`ifdef CNTR8_DECODER_AUTO_RESYNC_EN
        ST_ERR:  state_next = ST_SYNC;
`else
        ST_ERR:  state_next = ST_ERR;
`endif
        default: state_next = ST_IDLE;
      endcase
    end else if ((state_reg == 3'b110) || (state_reg == 3'b111)) begin
      // Unused codes recover to IDLE without waiting for a sample.
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      dout_reg  <= '0;
      wrap_reg  <= 1'b0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign state   = state_reg;
  assign d_out   = dout_reg;
  assign wrap    = wrap_reg;
  assign err_cnt = err_reg;

endmodule

// File: tb/tb_cntr8_decoder.sv
// ---------------------------------------------------------------------------
// tb_cntr8_decoder
// Drives directed and random sample streams into cntr8_decoder. The driver
// pushes the reference model's expected outputs into a queue at each clock
// edge; an independent monitor pops and compares on the falling edge.
// Directed spot checks compare against fixed values at key points.
// Honors CNTR8_DECODER_AUTO_RESYNC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cntr8_decoder;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] d;
    logic       w;
    logic [7:0] e;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       d_valid;
  logic [7:0] d_in;
  logic [2:0] state;
  logic [7:0] d_out;
  logic       wrap;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  exp_t exp_q[$];

  // Reference model: what has been seen since the last clear.
  bit m_have;      // at least one sample since clear
  bit m_tracking;  // a legal step has established a direction
  bit m_err;       // illegal jump seen while tracking
  int m_dir;       // +1, -1 or 0 for the last legal step
  int m_ref;       // last accepted sample, 0..255
  int m_errs;      // saturating error count
  bit m_wrap;

  cntr8_decoder #(
    .WIDTH (8),
    .ERR_W (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .d_valid (d_valid),
    .d_in    (d_in),
    .state   (state),
    .d_out   (d_out),
    .wrap    (wrap),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] model_code();
    if (!m_have)     return 3'd0;
    if (m_err)       return 3'd5;
    if (!m_tracking) return 3'd1;
    if (m_dir > 0)   return 3'd2;
    if (m_dir < 0)   return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_clear();
    m_have = 0; m_tracking = 0; m_err = 0; m_dir = 0;
    m_ref = 0; m_errs = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit v, input bit c, input logic [7:0] d);
    int diff;
    int nxt;
    m_wrap = 0;
    if (c) begin
      model_clear();
    end else if (v) begin
      diff = (int'(d) - m_ref + 256) % 256;
      if (!m_have) begin
        m_have = 1;
      end else if (m_err) begin
`ifdef CNTR8_DECODER_AUTO_RESYNC_EN
        m_err = 0;
        m_tracking = 0;
`endif
      end else if (diff == 0 || diff == 1 || diff == 255) begin
        m_dir = (diff == 1) ? 1 : ((diff == 255) ? -1 : 0);
        m_tracking = 1;
        nxt = m_ref + m_dir;
        m_wrap = (m_dir != 0) && (nxt < 0 || nxt > 255);
      end else if (m_tracking) begin
        m_err = 1;
        if (m_errs < 255) m_errs = m_errs + 1;
      end
      m_ref = int'(d);
    end
    exp_q.push_back('{st: model_code(), d: 8'(m_ref), w: m_wrap, e: 8'(m_errs)});
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock of stimulus; returns just after the accepting edge.
  task automatic drive(input bit v, input bit c, input logic [7:0] d);
    @(negedge clk);
    #2;
    d_valid = v;
    clr     = c;
    d_in    = d;
    @(posedge clk);
    model_step(v, c, d);
    #1;
  endtask

  task automatic async_reset(input int cycles);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_dout", int'(d_out), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    chk("async_rst_err", int'(err_cnt), 0);
    model_clear();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: every falling edge with a pending expectation is a transaction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: state=%b d_out=%h wrap=%b err_cnt=%h (exp %b %h %b %h)",
               n_txn, state, d_out, wrap, err_cnt, e.st, e.d, e.w, e.e);
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL sb_state txn %0d: got %b expected %b", n_txn, state, e.st);
      end
      n_checks++;
      if (d_out !== e.d) begin
        n_fail++;
        $display("FAIL sb_dout txn %0d: got %h expected %h", n_txn, d_out, e.d);
      end
      n_checks++;
      if (wrap !== e.w) begin
        n_fail++;
        $display("FAIL sb_wrap txn %0d: got %b expected %b", n_txn, wrap, e.w);
      end
      n_checks++;
      if (err_cnt !== e.e) begin
        n_fail++;
        $display("FAIL sb_err txn %0d: got %h expected %h", n_txn, err_cnt, e.e);
      end
    end
  end

  initial begin
    int r;
    int sel;
    logic [7:0] nd;

    reset_n = 1'b0;
    clr     = 1'b0;
    d_valid = 1'b0;
    d_in    = 8'h00;
    model_clear();
    #20;
    chk("reset_state", int'(state), 0);
    chk("reset_dout", int'(d_out), 0);
    chk("reset_err", int'(err_cnt), 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Lock, then down / hold / direction change.
    drive(1, 0, 8'h10); chk("lock_sync", int'(state), 1);
    drive(1, 0, 8'h11); chk("lock_inc", int'(state), 2);
    drive(1, 0, 8'h12); chk("lock_inc2", int'(state), 2);
    chk("lock_dout", int'(d_out), 8'h12);
    drive(1, 0, 8'h11); chk("dir_dec", int'(state), 3);
    drive(1, 0, 8'h11); chk("dir_hold", int'(state), 4);
    drive(1, 0, 8'h12); chk("dir_inc", int'(state), 2);
    chk("dir_err", int'(err_cnt), 0);

    // Wrap both ways.
    drive(0, 1, 8'h00);
    drive(1, 0, 8'hFE); chk("wrap_sync", int'(state), 1);
    drive(1, 0, 8'hFF); chk("wrap_pre", int'(wrap), 0);
    drive(1, 0, 8'h00); chk("wrap_up", int'(wrap), 1);
    chk("wrap_up_state", int'(state), 2);
    drive(0, 0, 8'h55); chk("wrap_up_once", int'(wrap), 0);
    drive(1, 0, 8'hFF); chk("wrap_down", int'(wrap), 1);
    chk("wrap_down_state", int'(state), 3);
    drive(1, 0, 8'hFE); chk("wrap_down_once", int'(wrap), 0);

    // Illegal jump.
    drive(0, 1, 8'h00);
    drive(1, 0, 8'h1F);
    drive(1, 0, 8'h20);
    drive(1, 0, 8'h40); chk("jump_state", int'(state), 5);
    chk("jump_err", int'(err_cnt), 1);
`ifdef CNTR8_DECODER_AUTO_RESYNC_EN
    drive(1, 0, 8'h41); chk("resync_sync", int'(state), 1);
    drive(1, 0, 8'h42); chk("resync_inc", int'(state), 2);
    // Saturation: relock then jump, repeatedly.
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 8'h43);
      drive(1, 0, 8'h90);
      drive(1, 0, 8'h42);
    end
    chk("sat_err", int'(err_cnt), 8'hFF);
`else
    drive(1, 0, 8'h41); chk("sticky_err", int'(state), 5);
    drive(1, 0, 8'h42); chk("sticky_err2", int'(state), 5);
    chk("sticky_cnt", int'(err_cnt), 1);
`endif

    // clr beats a wrap-eligible sample.
    drive(0, 1, 8'h00);
    drive(1, 0, 8'hFE);
    drive(1, 0, 8'hFF);
    drive(1, 1, 8'h00);
    chk("clr_state", int'(state), 0);
    chk("clr_err", int'(err_cnt), 0);
    chk("clr_wrap", int'(wrap), 0);
    chk("clr_dout", int'(d_out), 0);

    // Gaps in DEC leave everything unchanged.
    drive(1, 0, 8'h50);
    drive(1, 0, 8'h4F);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'($urandom));
      chk("gap_state", int'(state), 3);
      chk("gap_dout", int'(d_out), 8'h4F);
    end

    async_reset(2);

    // Randomized: mostly legal steps, some jumps, gaps and clears.
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: nd = 8'(m_ref + 1);
        3, 4, 5: nd = 8'(m_ref - 1);
        6, 7:    nd = 8'(m_ref);
        8:       nd = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: nd = 8'($urandom);
      endcase
      if (r < 4)       drive(($urandom_range(0, 1) != 0), 1, nd);
      else if (r < 20) drive(0, 0, nd);
      else             drive(1, 0, nd);
    end

    @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr8_decoder.md
Name: cntr8_decoder

Overview:
- Receive-side decoder for the 8-bit up/down counter output bus.
- Samples the counter value stream (d_in with d_valid) and classifies each step as increment, decrement, hold or illegal jump.
- Recovers the counter's operating state as a 3-bit code and flags wrap-around.
- Counts protocol errors; used as an on-chip monitor / checker on the counter datapath.

Parameters:
- WIDTH, 8, data width of observed counter value
- ERR_W, 8, width of saturating error counter

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear: return to IDLE, zero err_cnt
- d_valid  input  1  d_in carries a new counter sample this cycle
- d_in  input  WIDTH  observed counter value
- state  output  3  decoded state code (registered)
- d_out  output  WIDTH  last accepted sample (registered)
- wrap  output  1  one-cycle pulse on modular wrap (registered)
- err_cnt  output  ERR_W  saturating count of illegal steps

Behaviour:
- Reset (async, reset_n=0): state=IDLE, d_out=0, wrap=0, err_cnt=0. Takes effect immediately, mid-operation included.
- State codes:
  - IDLE=3'b000, SYNC=3'b001, INC=3'b010, DEC=3'b011, HOLD=3'b100, ERR=3'b101
  - 110/111 unused; if reached, next state is IDLE.
- All outputs are registered and update on the clk edge that accepts a sample (1-cycle latency).
- d_valid=0: state, d_out and err_cnt hold; wrap=0.
- Step classification, modulo 2^WIDTH, d_in against d_out:
  - d_in == d_out+1: "up"
  - d_in == d_out-1: "down"
  - d_in == d_out: "same"
  - anything else: "jump"
- Transitions on an accepted sample (d_valid=1):
  - IDLE: d_out<=d_in; go SYNC.
  - SYNC: up→INC, down→DEC, same→HOLD. Jump→stay SYNC, no error.
  - INC/DEC/HOLD: up→INC, down→DEC, same→HOLD (direction changes are legal). Jump→ERR, err_cnt+1.
  - ERR: d_out<=d_in; stays ERR (see Optional Feature).
  - d_out<=d_in on every accepted sample, in all states.
- wrap=1 for exactly one cycle when an accepted step is either:
  - up with d_out==all-ones and d_in==0, or
  - down with d_out==0 and d_in==all-ones.
  - Valid in SYNC/INC/DEC/HOLD.
- err_cnt saturates at all-ones (no wrap).
- clr=1 has priority over d_valid: state=IDLE, d_out=0, err_cnt=0, wrap=0 next edge.
- Simultaneous clr and wrap-eligible sample: clr wins, no wrap pulse.

Optional Feature:
- Macro CNTR8_DECODER_AUTO_RESYNC_EN.
- Defined: in ERR, an accepted sample moves to SYNC with d_out<=d_in. The decoder relocks without clr; err_cnt is retained.
- Undefined: ERR is sticky; only clr or reset_n leaves it.

Decomposition:
- Shared package cntr8_pkg:
  - 3-bit state code constants (IDLE..ERR)
  - step-class enum (UP, DOWN, SAME, JUMP)
  - default WIDTH
- One natural sub-module: cntr8_step_cmp, a combinational classifier. Inputs prev, cur; outputs step class and wrap_cand. FSM and counters stay in cntr8_decoder.

Test Plan:
- Reset/lock:
  - reset_n low 20ns → state=000, d_out=0, err_cnt=0.
  - Then samples 8'h10, 8'h11, 8'h12 → state 001, 010, 010; d_out=8'h12.
- Down, hold, direction change: after lock at 8'h12, samples 8'h11, 8'h11, 8'h12 → state 011, 100, 010; err_cnt=0.
- Wrap both ways:
  - Samples 8'hFE, 8'hFF, 8'h00 → INC, wrap pulses exactly once, on the cycle d_out becomes 8'h00.
  - Then 8'hFF → DEC, wrap pulses once.
- Illegal jump: locked INC at 8'h20, sample 8'h40 → state=101, err_cnt=1. Further samples:
  - macro undefined: stay 101
  - macro defined: 8'h41 → 001, then 8'h42 → 010
- Saturation and clr:
  - Force 300 jump errors (with resync macro, alternating lock/jump) → err_cnt=8'hFF.
  - Then clr=1 with d_valid=1 → state=000, err_cnt=0, wrap=0.
- Gaps and async reset: d_valid low for 5 cycles in DEC → all outputs unchanged. Assert reset_n mid-cycle → outputs clear before next clk edge.
